user_stimulus_gen: RTL and testbench
====================================

# user_stimulus_gen

Wishbone-programmable pattern generator instantiated inside the user project wrapper, directly upstream of the management-side GPIO/logic-analyzer checking used by the project IO stimulus test. It drives a configurable 32-bit pattern onto user IO pads 37:6 and mirrors the pattern and its update count onto the logic analyzer. Firmware copies these values back to management-controlled pads for the testbench monitor to check.

## Interface
- BASE_ADDR, 32'h3000_0000, Wishbone base address; only bits 31:8 are decoded.
- RST_PERIOD, 16'd0, reset value of the PERIOD register.
- wb_clk_i  in  1  single clock, rising edge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe, cycle and write-enable.
- wbs_sel_i  in  4  byte lanes; a write updates only the selected bytes.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  transfer acknowledge.
- wbs_dat_o  out  32  read data.
- io_out  out  38  pad outputs.
- io_oeb  out  38  pad output-enable, active-low.
- la_data_out  out  64  logic analyzer outputs.

## Operation
- Register offsets:
  - 0x00 CTRL: bit 0 EN; bits 2:1 MODE; bit 3 DRIVE; bit 4 CLR, write-1 self-clearing, reads 0.
  - 0x04 PERIOD: bits 15:0.
  - 0x08 SEED: bits 31:0.
  - 0x0C PATTERN: read-only.
  - 0x10 COUNT: read-only.
  - Unmapped offsets read 0 and ignore writes.
- MODE encoding:
  - 0 COUNT: pattern+1, modulo 2^32.
  - 1 LFSR: Galois, polynomial x^32+x^22+x^2+x+1, shift left, feedback mask 32'h0040_0007.
  - 2 WALK: rotate left by 1.
  - 3 HOLD: no change.
- Tick generation:
  - Period counter runs only while EN=1.
  - Tick fires when counter == PERIOD; counter then returns to 0. PERIOD=0 gives a tick every cycle.
  - On a tick (MODE≠HOLD): pattern advances and COUNT increments, wrapping 32'hFFFF_FFFF→0.
- SEED write:
  - Loads the pattern with the written value, or 32'h1 if the value is 0 and MODE is LFSR/WALK, so all-zero never locks up.
  - Zeroes the period counter.
  - Takes priority over a tick in the same cycle.
- CLR zeroes COUNT and the period counter; the pattern is unchanged. CLR wins over a simultaneous tick.
- EN 1→0 freezes pattern, COUNT and period counter. EN 0→1 resumes from the frozen period-counter value.
- Pad and LA mapping:
  - io_out[37:6] = pattern; io_out[5:0] = 0.
  - io_oeb[37:6] = {32{~DRIVE}}; io_oeb[5:0] = 6'h3F always (flash/UART/JTAG pads never driven).
  - la_data_out[31:0] = pattern; la_data_out[63:32] = COUNT.
- Reset values:
  - CTRL = 0, PERIOD = RST_PERIOD, SEED = 0, pattern = 0, COUNT = 0.
  - wbs_ack_o = 0, wbs_dat_o = 0.
  - io_out = 0, io_oeb = all ones, la_data_out = 0.

## Timing
- Wishbone:
  - Request = stb & cyc & address match & !ack.
  - wbs_ack_o is registered: asserted exactly one cycle after the request cycle and held for one cycle only. Back-to-back requests therefore complete every 2 cycles.
  - wbs_dat_o is valid in the ack cycle and is 0 otherwise.
  - Register writes take effect on the ack edge.
- Non-matching addresses are never acked; the wrapper's bus timeout handles them.
- Tick to pad latency: pattern register updates on the tick edge; io_out/la_data_out are combinational from registers, so pads change the same cycle.
- Reset asserted mid-transfer drops ack and returns all state to reset values on the next edge.

## Structure
- Package user_stimulus_pkg holds: register offset localparams, MODE enum (MODE_COUNT, MODE_LFSR, MODE_WALK, MODE_HOLD), LFSR_MASK constant.
- Sub-module stim_pattern_core:
  - Contains the period counter, pattern register and COUNT register.
  - Inputs: en, mode, period, seed_load, seed, clr.
  - Outputs: pattern, count.
- Top level holds the Wishbone decode and the CTRL/PERIOD/SEED registers.

## Test plan
- Reset: after wb_rst_i, io_oeb = 38'h3F_FFFF_FFFF, io_out = 0, and reads of 0x04/0x0C/0x10 return RST_PERIOD/0/0. Each access acks exactly one cycle after the request.
- COUNT mode, byte lanes: SEED=0xAB40, PERIOD=3, CTRL=0x9 → pattern steps 0xAB40, 0xAB41, … every 4 cycles; io_out[37:6] follows the pattern and io_oeb[37:6] = 0. A 1-byte wbs_sel_i write to PERIOD changes only that byte.
- LFSR zero-seed: MODE=LFSR, SEED=0 → pattern loads 1, next tick gives 2. Run 1000 ticks and check against a reference model; the pattern is never 0.
- WALK wrap-around: MODE=WALK, SEED=0x8000_0000, PERIOD=0 → next cycle 0x0000_0001. After 32 ticks the pattern returns to seed and COUNT reads 32.
- Simultaneous events: SEED write in a tick cycle → seed wins. CLR with a tick → COUNT=0. EN toggled mid-period → resumes with the correct remaining cycles.
- COUNT wrap and mid-run reset: preload via 2^32−2 ticks (force allowed) → COUNT wraps to 0. wb_rst_i mid-run → all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/user_stimulus_pkg.sv
// Shared constants, mode encoding and helpers for the user IO stimulus generator.
package user_stimulus_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned PERIOD_W = 16;

    localparam logic [7:0] OFF_CTRL    = 8'h00;
    localparam logic [7:0] OFF_PERIOD  = 8'h04;
    localparam logic [7:0] OFF_SEED    = 8'h08;
    localparam logic [7:0] OFF_PATTERN = 8'h0C;
    localparam logic [7:0] OFF_COUNT   = 8'h10;

    typedef enum logic [1:0] {
        MODE_COUNT = 2'd0,
        MODE_LFSR  = 2'd1,
        MODE_WALK  = 2'd2,
        MODE_HOLD  = 2'd3
    } mode_e;

    // Galois taps for x^32+x^22+x^2+x+1, shifting left
    localparam logic [DATA_W-1:0] LFSR_MASK = 32'h0040_0007;

    function automatic logic [DATA_W-1:0] next_pattern(input mode_e mode, input logic [DATA_W-1:0] cur);
        logic [DATA_W-1:0] nxt;
        nxt = cur;
        case (mode)
            MODE_COUNT: nxt = cur + DATA_W'(1);
            MODE_LFSR:  nxt = {cur[DATA_W-2:0], 1'b0} ^ (cur[DATA_W-1] ? LFSR_MASK : '0);
            MODE_WALK:  nxt = {cur[DATA_W-2:0], cur[DATA_W-1]};
            default:    nxt = cur;
        endcase
        return nxt;
    endfunction

    function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_val,
                                                     input logic [DATA_W-1:0] new_val,
                                                     input logic [3:0]        sel);
        logic [DATA_W-1:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/user_stimulus_gen_if.sv
// Wishbone slave bundle between the wrapper bus and the stimulus generator.
interface user_stimulus_gen_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/stim_pattern_core.sv
// Period counter, pattern register and update counter of the stimulus generator.
module stim_pattern_core
    import user_stimulus_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  mode_e               mode,
    input  logic [PERIOD_W-1:0] period,
    input  logic                seed_load,
    input  logic [DATA_W-1:0]   seed,
    input  logic                clr,
    output logic [DATA_W-1:0]   pattern,
    output logic [DATA_W-1:0]   count
);

    logic [PERIOD_W-1:0] cnt_q;
    logic [DATA_W-1:0]   pattern_q;
    logic [DATA_W-1:0]   count_q;
    logic                tick_c;
    logic                seed_fix_c;

    assign tick_c     = en && (cnt_q == period);
    // Zero would lock up LFSR/WALK, so substitute 1
    assign seed_fix_c = (seed == '0) && ((mode == MODE_LFSR) || (mode == MODE_WALK));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            pattern_q <= '0;
            count_q   <= '0;
        end else if (seed_load) begin
            pattern_q <= seed_fix_c ? DATA_W'(1) : seed;
            cnt_q     <= '0;
            if (clr) count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
            cnt_q   <= '0;
        end else if (en) begin
            cnt_q <= tick_c ? '0 : cnt_q + PERIOD_W'(1);
            if (tick_c && (mode != MODE_HOLD)) begin
                pattern_q <= next_pattern(mode, pattern_q);
                count_q   <= count_q + DATA_W'(1);
            end
        end
    end

    assign pattern = pattern_q;
    assign count   = count_q;

endmodule

// File: rtl/user_stimulus_gen.sv
// Wishbone-programmable 32-bit pattern generator driving user pads 37:6 and the LA.
module user_stimulus_gen
    import user_stimulus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter logic [15:0] RST_PERIOD = 16'd0
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    user_stimulus_gen_if.slave   wb,
    output logic [37:0]          io_out,
    output logic [37:0]          io_oeb,
    output logic [63:0]          la_data_out
);

    logic                ctrl_en_q;
    mode_e               ctrl_mode_q;
    logic                ctrl_drive_q;
    logic [PERIOD_W-1:0] period_q;
    logic [DATA_W-1:0]   seed_q;
    logic                ack_q;
    logic [DATA_W-1:0]   dat_q;

    logic [7:0]          offset_c;
    logic                req_c;
    logic                wr_c;
    logic                rd_c;
    logic                clr_c;
    logic                seed_load_c;
    logic [DATA_W-1:0]   seed_new_c;
    logic [DATA_W-1:0]   rd_data_c;
    logic [DATA_W-1:0]   pattern;
    logic [DATA_W-1:0]   count;

    assign offset_c    = wb.wbs_adr_i[7:0];
    assign req_c       = wb.wbs_stb_i && wb.wbs_cyc_i && !ack_q
                         && (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign wr_c        = req_c && wb.wbs_we_i;
    assign rd_c        = req_c && !wb.wbs_we_i;
    assign seed_new_c  = byte_merge(seed_q, wb.wbs_dat_i, wb.wbs_sel_i);
    assign seed_load_c = wr_c && (offset_c == OFF_SEED) && (wb.wbs_sel_i != 4'b0000);
    assign clr_c       = wr_c && (offset_c == OFF_CTRL) && wb.wbs_sel_i[0] && wb.wbs_dat_i[4];

    // Read mux; unmapped offsets return zero
    always_comb begin
        rd_data_c = '0;
        case (offset_c)
            OFF_CTRL:    rd_data_c = {28'd0, ctrl_drive_q, ctrl_mode_q, ctrl_en_q};
            OFF_PERIOD:  rd_data_c = {16'd0, period_q};
            OFF_SEED:    rd_data_c = seed_q;
            OFF_PATTERN: rd_data_c = pattern;
            OFF_COUNT:   rd_data_c = count;
            default:     rd_data_c = '0;
        endcase
    end

    // Bus response and writable registers; writes land on the edge that raises ack
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q        <= 1'b0;
            dat_q        <= '0;
            ctrl_en_q    <= 1'b0;
            ctrl_mode_q  <= MODE_COUNT;
            ctrl_drive_q <= 1'b0;
            period_q     <= RST_PERIOD;
            seed_q       <= '0;
        end else begin
            ack_q <= req_c;
            dat_q <= rd_c ? rd_data_c : '0;
            if (wr_c) begin
                case (offset_c)
                    OFF_CTRL: begin
                        if (wb.wbs_sel_i[0]) begin
                            ctrl_en_q    <= wb.wbs_dat_i[0];
                            ctrl_mode_q  <= mode_e'(wb.wbs_dat_i[2:1]);
                            ctrl_drive_q <= wb.wbs_dat_i[3];
                        end
                    end
                    OFF_PERIOD: begin
                        if (wb.wbs_sel_i[0]) period_q[7:0]  <= wb.wbs_dat_i[7:0];
                        if (wb.wbs_sel_i[1]) period_q[15:8] <= wb.wbs_dat_i[15:8];
                    end
                    OFF_SEED: seed_q <= seed_new_c;
                    default: ;
                endcase
            end
        end
    end

    stim_pattern_core u_core (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .en        (ctrl_en_q),
        .mode      (ctrl_mode_q),
        .period    (period_q),
        .seed_load (seed_load_c),
        .seed      (seed_new_c),
        .clr       (clr_c),
        .pattern   (pattern),
        .count     (count)
    );

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = dat_q;
    assign io_out       = {pattern, 6'd0};
    assign io_oeb       = {{32{~ctrl_drive_q}}, 6'h3F};
    assign la_data_out  = {count, pattern};

endmodule

// File: tb/tb_user_stimulus_gen.sv
// Directed bench for user_stimulus_gen: register access, pattern modes and event priority.
module tb_user_stimulus_gen;

    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h00;
    localparam logic [31:0] A_PER  = BASE + 32'h04;
    localparam logic [31:0] A_SEED = BASE + 32'h08;
    localparam logic [31:0] A_PAT  = BASE + 32'h0C;
    localparam logic [31:0] A_CNT  = BASE + 32'h10;

    logic        clk = 1'b0;
    logic        rst;
    logic [37:0] io_out;
    logic [37:0] io_oeb;
    logic [63:0] la_data_out;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] rdata;
    logic [31:0] model;
    logic        zero_seen;
    logic        stray_ack;

    user_stimulus_gen_if bus ();

    user_stimulus_gen #(
        .BASE_ADDR  (BASE),
        .RST_PERIOD (16'd0)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wb          (bus),
        .io_out      (io_out),
        .io_oeb      (io_oeb),
        .la_data_out (la_data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = 32'h0;
        bus.wbs_dat_i = 32'h0;
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        @(negedge clk);
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_we_i  = 1'b1;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = dat;
        bus.wbs_sel_i = sel;
        wait_cycles(1);
        check("wr_ack", 64'(bus.wbs_ack_o), 64'd1);
        bus_idle();
        wait_cycles(1);
        check("wr_ack_drop", 64'(bus.wbs_ack_o), 64'd0);
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
        @(negedge clk);
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_adr_i = adr;
        bus.wbs_sel_i = 4'hF;
        wait_cycles(1);
        check("rd_ack", 64'(bus.wbs_ack_o), 64'd1);
        dat = bus.wbs_dat_o;
        bus_idle();
        wait_cycles(1);
        check("rd_ack_drop", 64'(bus.wbs_ack_o), 64'd0);
        check("rd_dat_idle", 64'(bus.wbs_dat_o), 64'd0);
    endtask

    function automatic logic [31:0] lfsr_ref(input logic [31:0] p);
        logic [31:0] s;
        s = {p[30:0], 1'b0};
        if (p[31]) s = s ^ 32'h0040_0007;
        return s;
    endfunction

    initial begin
        bus_idle();
        rst = 1'b1;
        wait_cycles(2);
        check("rst_io_out", 64'(io_out), 64'd0);
        check("rst_io_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
        check("rst_la", la_data_out, 64'd0);
        check("rst_ack", 64'(bus.wbs_ack_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        wb_read(A_PER, rdata);  check("rst_period", 64'(rdata), 64'd0);
        wb_read(A_PAT, rdata);  check("rst_pattern", 64'(rdata), 64'd0);
        wb_read(A_CNT, rdata);  check("rst_count", 64'(rdata), 64'd0);
        wb_read(A_CTRL, rdata); check("rst_ctrl", 64'(rdata), 64'd0);

        // COUNT mode, period 3 -> one step every 4 cycles
        wb_write(A_SEED, 32'h0000_AB40, 4'hF);
        wb_write(A_PER, 32'd3, 4'hF);
        wb_write(A_CTRL, 32'h9, 4'hF);
        check("cnt_pat0", 64'(la_data_out[31:0]), 64'hAB40);
        check("cnt_io_out", 64'(io_out), {26'd0, 32'h0000_AB40, 6'd0});
        check("cnt_io_oeb", 64'(io_oeb), 64'h3F);
        wait_cycles(2); check("cnt_pat_hold", 64'(la_data_out[31:0]), 64'hAB40);
        wait_cycles(1); check("cnt_pat1", 64'(la_data_out[31:0]), 64'hAB41);
        wait_cycles(4); check("cnt_pat2", 64'(io_out[37:6]), 64'hAB42);
        check("cnt_count2", 64'(la_data_out[63:32]), 64'd2);
        wb_write(A_CTRL, 32'h8, 4'hF);
        wb_write(A_PER, 32'h0000_1200, 4'b0010);
        wb_read(A_PER, rdata); check("per_byte1", 64'(rdata), 64'h1203);
        wb_write(A_PER, 32'hFFFF_FF07, 4'b0001);
        wb_read(A_PER, rdata); check("per_byte0", 64'(rdata), 64'h1207);
        wb_read(A_PAT, rdata); check("frozen_pat", 64'(rdata), 64'hAB42);
        wb_read(A_CNT, rdata); check("frozen_cnt", 64'(rdata), 64'd2);

        // Unmapped offset acks and reads zero; foreign page never acks
        wb_write(BASE + 32'h14, 32'hDEAD_BEEF, 4'hF);
        wb_read(BASE + 32'h14, rdata); check("unmapped_rd", 64'(rdata), 64'd0);
        @(negedge clk);
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_adr_i = BASE + 32'h104;
        stray_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_cycles(1);
            stray_ack = stray_ack | bus.wbs_ack_o;
        end
        check("no_ack_foreign", 64'(stray_ack), 64'd0);
        bus_idle();

        // LFSR with zero seed loads 1, then 1000 ticks against the reference
        wb_write(A_CTRL, 32'hA, 4'hF);
        wb_write(A_SEED, 32'h0, 4'hF);
        check("lfsr_seed_fix", 64'(la_data_out[31:0]), 64'd1);
        wb_write(A_PER, 32'd0, 4'hF);
        wb_write(A_CTRL, 32'h1B, 4'hF);
        check("lfsr_first", 64'(la_data_out[31:0]), 64'd2);
        check("lfsr_cnt1", 64'(la_data_out[63:32]), 64'd1);
        model = 32'd2;
        zero_seen = 1'b0;
        for (int i = 1; i < 1000; i++) begin
            wait_cycles(1);
            model = lfsr_ref(model);
            if (la_data_out[31:0] == 32'd0) zero_seen = 1'b1;
            check("lfsr_run", 64'(la_data_out[31:0]), 64'(model));
        end
        check("lfsr_no_zero", 64'(zero_seen), 64'd0);
        check("lfsr_cnt1000", 64'(la_data_out[63:32]), 64'd1000);
        wb_write(A_CTRL, 32'hA, 4'hF);
        model = lfsr_ref(model);
        check("lfsr_stop_pat", 64'(la_data_out[31:0]), 64'(model));
        check("lfsr_stop_cnt", 64'(la_data_out[63:32]), 64'd1001);

        // WALK wraps bit 31 into bit 0 and returns to seed after 32 ticks
        wb_write(A_CTRL, 32'hC, 4'hF);
        wb_write(A_SEED, 32'h8000_0000, 4'hF);
        wb_write(A_CTRL, 32'h1D, 4'hF);
        check("walk_wrap", 64'(la_data_out[31:0]), 64'd1);
        wait_cycles(31);
        check("walk_back", 64'(la_data_out[31:0]), 64'h8000_0000);
        check("walk_cnt32", 64'(la_data_out[63:32]), 64'd32);
        wb_write(A_CTRL, 32'hC, 4'hF);
        wb_read(A_CNT, rdata); check("walk_rd_cnt", 64'(rdata), 64'd33);
        wb_read(A_PAT, rdata); check("walk_rd_pat", 64'(rdata), 64'd1);

        // Seed write and CLR landing on tick edges
        wb_write(A_CTRL, 32'h8, 4'hF);
        wb_write(A_SEED, 32'h100, 4'hF);
        wb_write(A_CTRL, 32'h9, 4'hF);
        check("sim_tick", 64'(la_data_out[31:0]), 64'h101);
        wb_write(A_SEED, 32'h5555, 4'hF);
        check("seed_wins", 64'(la_data_out[31:0]), 64'h5556);
        wb_write(A_CTRL, 32'h19, 4'hF);
        check("clr_wins", 64'(la_data_out[63:32]), 64'd1);

        // EN dropped after 3 of 6 cycles resumes with 3 remaining
        wb_write(A_CTRL, 32'h8, 4'hF);
        wb_write(A_PER, 32'd5, 4'hF);
        wb_write(A_SEED, 32'h200, 4'hF);
        wb_write(A_CTRL, 32'h9, 4'hF);
        wait_cycles(1);
        wb_write(A_CTRL, 32'h8, 4'hF);
        check("en_freeze0", 64'(la_data_out[31:0]), 64'h200);
        wait_cycles(10);
        check("en_freeze1", 64'(la_data_out[31:0]), 64'h200);
        wb_write(A_CTRL, 32'h9, 4'hF);
        check("en_resume0", 64'(la_data_out[31:0]), 64'h200);
        wait_cycles(1);
        check("en_resume1", 64'(la_data_out[31:0]), 64'h200);
        wait_cycles(1);
        check("en_resume_tick", 64'(la_data_out[31:0]), 64'h201);

        // COUNT register wraps from all-ones to zero
        wb_write(A_CTRL, 32'h8, 4'hF);
        wb_write(A_PER, 32'd0, 4'hF);
        wb_write(A_SEED, 32'h300, 4'hF);
        @(negedge clk);
        force dut.u_core.count_q = 32'hFFFF_FFFE;
        #1;
        release dut.u_core.count_q;
        #1;
        check("wrap_preload", 64'(la_data_out[63:32]), 64'hFFFF_FFFE);
        wb_write(A_CTRL, 32'h9, 4'hF);
        check("wrap_max", 64'(la_data_out[63:32]), 64'hFFFF_FFFF);
        check("wrap_pat", 64'(la_data_out[31:0]), 64'h301);
        wait_cycles(1);
        check("wrap_zero", 64'(la_data_out[63:32]), 64'd0);

        // Reset during a running generator and an in-flight read
        @(negedge clk);
        rst = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_adr_i = A_PAT;
        wait_cycles(1);
        check("mid_rst_ack", 64'(bus.wbs_ack_o), 64'd0);
        check("mid_rst_dat", 64'(bus.wbs_dat_o), 64'd0);
        check("mid_rst_io_out", 64'(io_out), 64'd0);
        check("mid_rst_io_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
        check("mid_rst_la", la_data_out, 64'd0);
        bus_idle();
        @(negedge clk);
        rst = 1'b0;
        wb_read(A_CTRL, rdata); check("post_rst_ctrl", 64'(rdata), 64'd0);
        wb_read(A_SEED, rdata); check("post_rst_seed", 64'(rdata), 64'd0);
        wb_read(A_PER, rdata);  check("post_rst_period", 64'(rdata), 64'd0);
        wb_read(A_CNT, rdata);  check("post_rst_count", 64'(rdata), 64'd0);
        wait_cycles(3);
        check("post_rst_idle", la_data_out, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
